// File: rtl/demod_frame_ctrl.sv
// Symbol-timing and framing controller: strobes the demodulator each symbol period,
// samples the decided symbol, hunts for the sync word and delivers length-prefixed payload bytes.
module demod_frame_ctrl #(
  parameter int unsigned SYM_LEN      = 128,
  parameter int unsigned SAMPLE_DELAY = 2,
  parameter logic [15:0] SYNC_WORD    = 16'hE5A3,
  parameter int unsigned MAX_LEN      = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       sym_strobe,
  input  logic [1:0] sym_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       locked,
  output logic       frame_done,
  output logic       frame_err,
  output logic       overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HUNT,
    S_HEADER,
    S_PAYLOAD,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_CNT_MAX = 8'(SYM_LEN - 1);
  localparam logic [7:0] LP_SAMPLE  = 8'(SAMPLE_DELAY);
  localparam logic [7:0] LP_MAX_LEN = 8'(MAX_LEN);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_cnt;
  logic        r_primed;
  // Only the last 7 symbols need keeping: the 8th comes straight from sym_in.
  logic [13:0] r_sh;
  logic [3:0]  r_nsh;
  logic [1:0]  r_k;
  logic [5:0]  r_acc;
  logic [7:0]  r_remaining;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_overflow;
  logic        r_frame_err;
  logic        r_locked;
  logic        r_frame_done;
  logic        w_locked_nxt;
  logic        w_done_nxt;

  logic        w_sym_evt;
  logic [15:0] w_sh_next;
  logic [3:0]  w_nsh_next;
  logic        w_sync_hit;
  logic        w_in_frame;
  logic [7:0]  w_byte;
  logic        w_byte_done;
  logic        w_len_bad;
  logic        w_accept;

  assign sym_strobe  = enable && (r_cnt == LP_CNT_MAX);
  assign w_sym_evt   = enable && r_primed && (r_cnt == LP_SAMPLE);
  assign w_sh_next   = {r_sh, sym_in};
  assign w_nsh_next  = (r_nsh == 4'd8) ? 4'd8 : r_nsh + 4'd1;
  assign w_sync_hit  = (r_state == S_HUNT) && w_sym_evt &&
                       (w_sh_next == SYNC_WORD) && (w_nsh_next == 4'd8);
  assign w_in_frame  = (r_state == S_HEADER) || (r_state == S_PAYLOAD);
  assign w_byte      = {r_acc, sym_in};
  assign w_byte_done = w_in_frame && w_sym_evt && (r_k == 2'd3);
  assign w_len_bad   = (w_byte == 8'd0) || (w_byte > LP_MAX_LEN);
  assign w_accept    = !r_out_valid || out_ready;

  // Symbol timer; the first strobe after enable arms sampling.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (!reset) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
    end else if (!enable) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
    end else begin
      r_cnt <= (r_cnt == LP_CNT_MAX) ? 8'd0 : r_cnt + 8'd1;
      if (sym_strobe) r_primed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: defaulting every comb output first keeps latches from being inferred.
    w_next_state = r_state;
    if (!enable) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_next_state = S_HUNT;
        S_HUNT:    if (w_sync_hit) w_next_state = S_HEADER;
        S_HEADER:  if (w_byte_done) w_next_state = w_len_bad ? S_HUNT : S_PAYLOAD;
        S_PAYLOAD: if (w_byte_done && (r_remaining == 8'd1)) w_next_state = S_DONE;
        S_DONE:    w_next_state = S_HUNT;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the next state and registered, so they are glitch-free.
  always_comb begin
    w_locked_nxt = (w_next_state == S_HEADER) || (w_next_state == S_PAYLOAD);
    w_done_nxt   = (w_next_state == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh         <= '0;
      r_nsh        <= '0;
      r_k          <= '0;
      r_acc        <= '0;
      r_remaining  <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_locked     <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (!enable) begin
      r_sh         <= '0;
      r_nsh        <= '0;
      r_k          <= '0;
      r_acc        <= '0;
      r_remaining  <= '0;
      r_out_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_locked     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_locked     <= w_locked_nxt;
      r_frame_done <= w_done_nxt;
      r_frame_err  <= (r_state == S_HEADER) && w_byte_done && w_len_bad;

      if (r_out_valid && out_ready) r_out_valid <= 1'b0;

      if ((r_state == S_HUNT) && w_sym_evt) begin
        if (w_sync_hit) begin
          r_sh  <= '0;
          r_nsh <= '0;
          r_k   <= '0;
        end else begin
          r_sh  <= w_sh_next[13:0];
          r_nsh <= w_nsh_next;
        end
      end

      if (w_in_frame && w_sym_evt) begin
        r_acc <= w_byte[5:0];
        r_k   <= r_k + 2'd1;
      end

      if ((r_state == S_HEADER) && w_byte_done && !w_len_bad) r_remaining <= w_byte;

      // A new byte may replace one being transferred this cycle; otherwise it is dropped.
      if ((r_state == S_PAYLOAD) && w_byte_done) begin
        r_remaining <= r_remaining - 8'd1;
        if (w_accept) begin
          r_out_data  <= w_byte;
          r_out_valid <= 1'b1;
        end else begin
          r_overflow  <= 1'b1;
        end
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;
  assign locked     = r_locked;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_demod_frame_ctrl.sv
// Scoreboard bench for demod_frame_ctrl: expected payload bytes are queued as symbols are
// driven and compared when the DUT hands them over.
module tb_demod_frame_ctrl;

  localparam int          SYM_LEN = 16;
  localparam int          SD      = 3;
  localparam logic [15:0] SYNC    = 16'hE5A3;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       sym_strobe;
  logic [1:0] sym_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       locked;
  logic       frame_done;
  logic       frame_err;
  logic       overflow;

  always #5 clk = ~clk;

  demod_frame_ctrl #(
    .SYM_LEN(SYM_LEN), .SAMPLE_DELAY(SD), .SYNC_WORD(SYNC), .MAX_LEN(64)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sym_strobe(sym_strobe),
    .sym_in(sym_in), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .locked(locked), .frame_done(frame_done),
    .frame_err(frame_err), .overflow(overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int n_done = 0, n_err = 0, n_xfer = 0, n_valid_cyc = 0, n_done_rise = 0, n_locked_cyc = 0;
  logic       locked_before_done = 1'b0;
  logic [7:0] done_data = '0;
  logic       prev_valid = 1'b0, prev_xfer = 1'b0, prev_locked = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: handshake scoreboard, hold stability and event counters.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid) n_valid_cyc++;
      if (locked)    n_locked_cyc++;
      if (frame_err) n_err++;
      if (frame_done) begin
        n_done++;
        locked_before_done = prev_locked;
        done_data          = out_data;
        if (out_valid && !prev_valid) n_done_rise++;
      end
      if (prev_valid && !prev_xfer && out_valid) check("hold_data", out_data, prev_data);
      if (out_valid && out_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) check("sb_extra", out_data, 32'h100);
        else                   check("sb_data", out_data, exp_q.pop_front());
      end
      prev_valid  = out_valid;
      prev_xfer   = out_valid && out_ready;
      prev_data   = out_data;
      prev_locked = locked;
    end else begin
      prev_valid  = 1'b0;
      prev_xfer   = 1'b0;
      prev_locked = 1'b0;
    end
  end

  // Drives one symbol right at the next strobe, as the demodulator would.
  task automatic send_sym(input logic [1:0] s);
    int w = 0;
    @(negedge clk);
    while (!sym_strobe && w < SYM_LEN + 4) begin
      @(negedge clk);
      w++;
    end
    if (!sym_strobe) check("strobe_wait", sym_strobe, 1);
    sym_in = s;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) send_sym(b[7-2*i -: 2]);
  endtask

  task automatic send_sync();
    send_byte(SYNC[15:8]);
    send_byte(SYNC[7:0]);
  endtask

  // Negedges from the strobe of the last driven symbol until the selected flag goes high.
  task automatic measure(input string tag, input bit use_locked, input int exp_lat);
    int   n   = 0;
    logic hit = 1'b0;
    while (!hit && n < exp_lat + 6) begin
      @(negedge clk);
      n++;
      hit = use_locked ? locked : frame_err;
    end
    check(tag, n, exp_lat);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, per, d0, x0, v0, r0, e0;
    logic [15:0] tsh;
    logic [1:0]  s;
    int ovl[11] = '{3, 2, 1, 3, 2, 1, 1, 2, 2, 0, 3};

    reset = 1'b0; enable = 1'b1; out_ready = 1'b1; sym_in = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_strobe", sym_strobe, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_locked", locked, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_ovf", overflow, 0);

    // Strobe timing: cycle 1 is the first enabled cycle after reset release.
    reset = 1'b1;
    cyc = 1;
    while (!sym_strobe && cyc < SYM_LEN + 8) begin
      @(negedge clk);
      cyc++;
    end
    check("first_strobe_cycle", cyc, SYM_LEN);
    repeat (2) begin
      @(negedge clk);
      check("strobe_width", sym_strobe, 0);
      per = 1;
      while (!sym_strobe && per < SYM_LEN + 8) begin
        @(negedge clk);
        per++;
      end
      check("strobe_period", per, SYM_LEN);
    end

    // Good frame, L=2.
    d0 = n_done; x0 = n_xfer; v0 = n_valid_cyc; r0 = n_done_rise;
    send_sync();
    measure("lock_latency", 1'b1, SD + 2);
    send_byte(8'h02);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A);
    check("locked_in_payload", locked, 1);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3);
    settle(SD + 4);
    check("good_xfers", n_xfer - x0, 2);
    check("good_valid_cycles", n_valid_cyc - v0, 2);
    check("good_done_count", n_done - d0, 1);
    check("good_done_with_valid", n_done_rise - r0, 1);
    check("good_done_data", done_data, 8'hC3);
    check("locked_until_done", locked_before_done, 1);
    check("good_unlocked_after", locked, 0);
    check("good_sb_empty", exp_q.size(), 0);

    // Illegal lengths: 0 and MAX_LEN+1.
    e0 = n_err; v0 = n_valid_cyc;
    send_sync();
    send_byte(8'h00);
    measure("err_latency_len0", 1'b0, SD + 2);
    check("unlocked_after_len0", locked, 0);
    send_sync();
    send_byte(8'h41);
    measure("err_latency_len65", 1'b0, SD + 2);
    check("unlocked_after_len65", locked, 0);
    settle(2);
    check("bad_err_count", n_err - e0, 2);
    check("bad_no_valid", n_valid_cyc - v0, 0);

    // Backpressure: L=3 with the consumer stalled.
    set_ready(1'b0);
    d0 = n_done; x0 = n_xfer;
    exp_q.push_back(8'h12);
    send_sync();
    send_byte(8'h03);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    settle(SD + 4);
    check("bp_valid_held", out_valid, 1);
    check("bp_data_held", out_data, 8'h12);
    check("bp_overflow", overflow, 1);
    check("bp_done_count", n_done - d0, 1);
    check("bp_no_xfer", n_xfer - x0, 0);
    set_ready(1'b1);
    settle(3);
    check("bp_one_xfer", n_xfer - x0, 1);
    check("bp_valid_cleared", out_valid, 0);
    check("bp_sb_empty", exp_q.size(), 0);
    check("bp_overflow_sticky", overflow, 1);

    // Enable drop mid-payload of an L=4 frame.
    set_ready(1'b0);
    d0 = n_done; e0 = n_err;
    exp_q.push_back(8'h6C);
    send_sync();
    send_byte(8'h04);
    send_byte(8'h6C);
    send_byte(8'h9F);
    settle(SD + 4);
    check("drop_pre_valid", out_valid, 1);
    check("drop_pre_data", out_data, 8'h6C);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("drop_valid", out_valid, 0);
    check("drop_overflow", overflow, 0);
    check("drop_locked", locked, 0);
    check("drop_strobe", sym_strobe, 0);
    exp_q.delete();
    settle(5);
    check("drop_no_done", n_done - d0, 0);
    check("drop_no_err", n_err - e0, 0);
    enable = 1'b1;
    set_ready(1'b1);
    d0 = n_done; x0 = n_xfer;
    exp_q.push_back(8'hA5);
    send_sync();
    send_byte(8'h01);
    send_byte(8'hA5);
    settle(SD + 4);
    check("reen_xfer", n_xfer - x0, 1);
    check("reen_done", n_done - d0, 1);
    check("reen_sb_empty", exp_q.size(), 0);

    // Sync following a false partial match.
    e0 = n_err;
    for (int i = 0; i < 10; i++) send_sym(ovl[i][1:0]);
    send_sym(ovl[10][1:0]);
    check("ovl_no_early_lock", locked, 0);
    measure("ovl_lock_latency", 1'b1, SD + 2);
    send_byte(8'h00);
    settle(SD + 4);
    check("ovl_err", n_err - e0, 1);

    // Random noise that never forms the sync word.
    e0 = n_err; x0 = n_xfer;
    n_locked_cyc = 0;
    tsh = '0;
    for (int i = 0; i < 1000; i++) begin
      s = 2'($urandom_range(0, 3));
      if ({tsh[13:0], s} == SYNC) s = s ^ 2'd1;
      tsh = {tsh[13:0], s};
      send_sym(s);
    end
    settle(SYM_LEN + 4);
    check("noise_locked_cycles", n_locked_cyc, 0);
    check("noise_no_err", n_err - e0, 0);
    check("noise_no_xfer", n_xfer - x0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
